// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters. Each cycle
//   at most one request is granted (round-robin on ties). The granted request
//   drives the ALU ports, and the ALU outputs are captured into a one-entry
//   result register with a valid/ready handshake.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   flush           : drop the held result, no grant this cycle
//   reqN_*          : requester N operands/controls/tag, valid/ready handshake
//   alu_*  (out)    : drive to the external ALU, all zero while idle
//   alu_result/zero : sampled from the external ALU
//   res_*           : captured result, valid/ready handshake to consumer
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_srca,
  input  logic [31:0]      req0_srcb,
  input  logic [3:0]       req0_aluctl,
  input  logic [1:0]       req0_brctl,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_srca,
  input  logic [31:0]      req1_srcb,
  input  logic [3:0]       req1_aluctl,
  input  logic [1:0]       req1_brctl,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      alu_srca,
  output logic [31:0]      alu_srca_shift,
  output logic [31:0]      alu_srcb,
  output logic [3:0]       alu_ctl,
  output logic [1:0]       alu_brctl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_zero,
  output logic             res_id,
  output logic [TAG_W-1:0] res_tag
);

  typedef struct packed {
    logic [31:0]      srca;
    logic [31:0]      srcb;
    logic [3:0]       aluctl;
    logic [1:0]       brctl;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t       w_req0, w_req1, w_sel;
  logic       w_slot_free;
  logic       w_gnt0, w_gnt1, w_gnt, w_gnt_id;

  logic             r_valid;
  logic [31:0]      r_data;
  logic             r_zero;
  logic             r_id;
  logic [TAG_W-1:0] r_tag;
  logic             r_last;

  assign w_req0 = '{srca: req0_srca, srcb: req0_srcb, aluctl: req0_aluctl,
                    brctl: req0_brctl, tag: req0_tag};
  assign w_req1 = '{srca: req1_srca, srcb: req1_srcb, aluctl: req1_aluctl,
                    brctl: req1_brctl, tag: req1_tag};

  // A held result that is being drained this cycle frees the slot, so a new
  // op can be accepted back-to-back.
  assign w_slot_free = !r_valid || res_ready;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && !flush && w_slot_free) begin
      if (req0_valid && req1_valid) begin
        // tie: favour whoever was not granted last
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_gnt    = w_gnt0 || w_gnt1;
  assign w_gnt_id = w_gnt1;

  // Idle drives all zeros (ADD 0+0) to keep the ALU inputs quiet.
  always_comb begin
    w_sel = '0;
    if (w_gnt0)      w_sel = w_req0;
    else if (w_gnt1) w_sel = w_req1;
  end

  assign req0_ready     = w_gnt0;
  assign req1_ready     = w_gnt1;
  assign alu_srca       = w_sel.srca;
  assign alu_srca_shift = w_sel.srca;
  assign alu_srcb       = w_sel.srcb;
  assign alu_ctl        = w_sel.aluctl;
  assign alu_brctl      = w_sel.brctl;

  // Priority: rst > flush > accept > drain. Grant is already masked by rst
  // and flush, so accept never fires in those cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_id    <= 1'b0;
      r_tag   <= '0;
      r_last  <= 1'b1;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_gnt) begin
      r_valid <= 1'b1;
      r_data  <= alu_result;
      r_zero  <= alu_zero;
      r_id    <= w_gnt_id;
      r_tag   <= w_sel.tag;
      r_last  <= w_gnt_id;
    end else if (r_valid && res_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_zero  = r_zero;
  assign res_id    = r_id;
  assign res_tag   = r_tag;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
// ALU model: ctl 0 ADD, 1 SUB, 2 AND, 3 OR; brctl 00 signed lt, 01 unsigned
// lt, 10 eq, 11 ne drives Zero.
module tb_alu_share_arbiter;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]       req0_aluctl, req1_aluctl;
  logic [1:0]       req0_brctl, req1_brctl;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      alu_srca, alu_srca_shift, alu_srcb, alu_result;
  logic [3:0]       alu_ctl;
  logic [1:0]       alu_brctl;
  logic             alu_zero;
  logic             res_valid, res_ready, res_zero, res_id;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca),
    .req0_srcb(req0_srcb), .req0_aluctl(req0_aluctl), .req0_brctl(req0_brctl),
    .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca),
    .req1_srcb(req1_srcb), .req1_aluctl(req1_aluctl), .req1_brctl(req1_brctl),
    .req1_tag(req1_tag),
    .alu_srca(alu_srca), .alu_srca_shift(alu_srca_shift), .alu_srcb(alu_srcb),
    .alu_ctl(alu_ctl), .alu_brctl(alu_brctl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_id(res_id), .res_tag(res_tag)
  );

  always_comb begin
    case (alu_ctl)
      4'd0:    alu_result = alu_srca + alu_srcb;
      4'd1:    alu_result = alu_srca - alu_srcb;
      4'd2:    alu_result = alu_srca & alu_srcb;
      4'd3:    alu_result = alu_srca | alu_srcb;
      default: alu_result = 32'd0;
    endcase
    case (alu_brctl)
      2'b00:   alu_zero = ($signed(alu_srca) < $signed(alu_srcb));
      2'b01:   alu_zero = (alu_srca < alu_srcb);
      2'b10:   alu_zero = (alu_srca == alu_srcb);
      default: alu_zero = (alu_srca != alu_srcb);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    else n_pass++;
  endtask

  // advance one clock, land 1 time unit past the edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic [1:0] br, input logic [3:0] t);
    req0_valid = v; req0_srca = a; req0_srcb = b;
    req0_aluctl = c; req0_brctl = br; req0_tag = t;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic [1:0] br, input logic [3:0] t);
    req1_valid = v; req1_srca = a; req1_srcb = b;
    req1_aluctl = c; req1_brctl = br; req1_tag = t;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    set0(1'b1, 32'd4, 32'd4, 4'd0, 2'b00, 4'd0);
    set1(1'b0, 0, 0, 4'd0, 2'b00, 4'd0);
    tick(); tick();

    // reset state; requester valid but rst masks the grant
    chk("rst_valid", res_valid, 0);
    chk("rst_data",  res_data, 0);
    chk("rst_zero",  res_zero, 0);
    chk("rst_id",    res_id, 0);
    chk("rst_tag",   res_tag, 0);
    chk("rst_rdy0",  req0_ready, 0);
    chk("rst_srca",  alu_srca, 0);

    // 1: single req0 ADD 5+7
    rst = 1'b0;
    set0(1'b1, 32'd5, 32'd7, 4'd0, 2'b10, 4'd3);
    #1;
    chk("t1_rdy0",  req0_ready, 1);
    chk("t1_rdy1",  req1_ready, 0);
    chk("t1_srca",  alu_srca, 5);
    chk("t1_shift", alu_srca_shift, 5);
    chk("t1_srcb",  alu_srcb, 7);
    tick();
    set0(1'b0, 0, 0, 4'd0, 2'b00, 4'd0);
    chk("t1_valid", res_valid, 1);
    chk("t1_data",  res_data, 12);
    chk("t1_id",    res_id, 0);
    chk("t1_tag",   res_tag, 3);
    #1;
    chk("t1_idle_ctl", alu_ctl, 0);
    tick();
    chk("t1_drain", res_valid, 0);

    // 2: both valid from reset -> 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    set0(1'b1, 32'd10, 32'd1, 4'd0, 2'b00, 4'd1);
    set1(1'b1, 32'd20, 32'd2, 4'd0, 2'b00, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_id",   res_id, i % 2);
      chk("t2_data", res_data, (i % 2 == 0) ? 11 : 22);
    end

    // 3: stall with req1 SUB 3-9 pending
    set0(1'b0, 0, 0, 4'd0, 2'b00, 4'd0);
    set1(1'b1, 32'd3, 32'd9, 4'd1, 2'b00, 4'd9);
    res_ready = 1'b0;
    #1;
    chk("t3_stall_rdy1", req1_ready, 0);
    chk("t3_stall_srca", alu_srca, 0);
    tick();
    chk("t3_hold_valid", res_valid, 1);
    chk("t3_hold_data",  res_data, 22);
    chk("t3_hold_tag",   res_tag, 2);
    res_ready = 1'b1;
    #1;
    chk("t3_rdy1", req1_ready, 1);
    tick();
    set1(1'b0, 0, 0, 4'd0, 2'b00, 4'd0);
    chk("t3_data", res_data, 32'hFFFF_FFFA);
    chk("t3_id",   res_id, 1);
    chk("t3_tag",  res_tag, 9);

    // 4: branch compare via Zero
    set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 2'b00, 4'd4);
    tick();
    chk("t4_slt_zero", res_zero, 1);
    set0(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 2'b01, 4'd5);
    tick();
    chk("t4_ult_zero", res_zero, 0);

    // 5: flush with a held result and req0 pending
    set0(1'b1, 32'd1, 32'd1, 4'd0, 2'b00, 4'd6);
    flush = 1'b1;
    #1;
    chk("t5_flush_rdy0", req0_ready, 0);
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", res_valid, 0);
    #1;
    chk("t5_rdy0", req0_ready, 1);
    tick();
    chk("t5_valid", res_valid, 1);
    chk("t5_data",  res_data, 2);
    chk("t5_tag",   res_tag, 6);

    // 6: rst mid-stream, both valid; last grant was 0 so req1 goes first
    set1(1'b1, 32'd20, 32'd2, 4'd0, 2'b00, 4'd2);
    #1;
    chk("t6_pre_rdy1", req1_ready, 1);
    tick();
    chk("t6_pre_id", res_id, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_rdy0", req0_ready, 0);
    chk("t6_rst_rdy1", req1_ready, 0);
    tick();
    chk("t6_rst_valid", res_valid, 0);
    rst = 1'b0;
    #1;
    chk("t6_post_rdy0", req0_ready, 1);
    chk("t6_post_rdy1", req1_ready, 0);
    tick();
    chk("t6_post_id",   res_id, 0);
    chk("t6_post_data", res_data, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
